// File: rtl/endian_block_packer_pkg.sv
// Shared constants for the block packer: default word/block widths and byte width.
package endian_block_packer_pkg;
  localparam int IN_W_DEF  = 64;
  localparam int BLK_W_DEF = 128;
  localparam int BYTE_W    = 8;
endpackage

// File: rtl/rev_bytes.sv
// Full-width byte-order reversal: byte i of din lands on byte NB-1-i of dout.
module rev_bytes
  import endian_block_packer_pkg::*;
#(
  parameter int SIZE = BLK_W_DEF
) (
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] dout
);
  localparam int NB = SIZE / BYTE_W;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign dout[i*BYTE_W +: BYTE_W] = din[(NB-1-i)*BYTE_W +: BYTE_W];
  end
endmodule

// File: rtl/endian_block_packer.sv
// Packs IN_W-bit host words into BLK_W-bit blocks (first word at the MSBs), with
// optional per-block byte reversal, double-buffered behind a valid/ready output.
module endian_block_packer
  import endian_block_packer_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int BLK_W = BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             swap_en,
  output logic [BLK_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);
  localparam int N  = BLK_W / IN_W;
  localparam int CW = $clog2(N);

  if ((IN_W % BYTE_W) != 0 || (BLK_W % BYTE_W) != 0 || (BLK_W % IN_W) != 0 || N < 2) begin : g_bad_cfg
    $error("endian_block_packer: illegal IN_W/BLK_W combination");
  end

  logic [CW-1:0]    cnt;
  logic [BLK_W-1:0] fill;
  logic [BLK_W-1:0] fill_nxt;
  logic [BLK_W-1:0] fill_rev;
  logic             fill_full;
  logic             fill_last;
  logic             swap_q;
  logic             accept;
  logic             xfer;
  logic             closing;

  // The output register frees up either when it is empty or is being drained
  // this cycle; in_ready deliberately follows out_ready combinationally.
  assign xfer     = fill_full & (~out_valid | out_ready);
  assign in_ready = ~fill_full | xfer;
  assign accept   = in_valid & in_ready;
  assign closing  = accept & (in_last | (cnt == CW'(N - 1)));
  assign busy     = fill_full | out_valid | (cnt != '0);

  rev_bytes #(.SIZE(BLK_W)) u_rev (
    .din  (fill),
    .dout (fill_rev)
  );

  // A first word wipes the whole buffer so short blocks carry zero padding and
  // nothing stale from the block being transferred on the same edge survives.
  always_comb begin
    fill_nxt = fill;
    if (accept) begin
      if (cnt == '0) begin
        fill_nxt = '0;
      end
      for (int w = 0; w < N; w++) begin
        if (int'(cnt) == w) begin
          fill_nxt[BLK_W-1-w*IN_W -: IN_W] = in_data;
        end
      end
    end
  end

  // Fill stage: word gathering and block close
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      fill      <= '0;
      fill_full <= 1'b0;
      fill_last <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      if (accept) begin
        fill <= fill_nxt;
        if (cnt == '0) begin
          swap_q <= swap_en;
        end
        cnt <= closing ? '0 : cnt + CW'(1);
      end
      // A one-word block closing on the transfer edge keeps fill occupied.
      if (closing) begin
        fill_full <= 1'b1;
        fill_last <= in_last;
      end else if (xfer) begin
        fill_full <= 1'b0;
      end
    end
  end

  // Output stage: transfer with optional reversal, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (xfer) begin
        out_data  <= swap_q ? fill_rev : fill;
        out_last  <= fill_last;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_endian_block_packer.sv
// Scoreboard bench for endian_block_packer: a word-list reference model predicts
// each block; an independent monitor checks every output handshake in order.
module tb_endian_block_packer;
  localparam int IN_W  = 64;
  localparam int BLK_W = 128;
  localparam int N     = BLK_W / IN_W;

  typedef struct packed {
    logic [BLK_W-1:0] d;
    logic             l;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             swap_en;
  logic [BLK_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stalls = 0;
  bit bp_en = 0;

  exp_t             exp_q[$];
  int               pop_cyc[$];
  logic [BLK_W-1:0] last_out;
  logic             last_outl;

  logic [IN_W-1:0]  m_words[$];
  bit               m_swap;

  endian_block_packer #(.IN_W(IN_W), .BLK_W(BLK_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .swap_en   (swap_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [BLK_W-1:0] ref_rev(input logic [BLK_W-1:0] b);
    logic [BLK_W-1:0] r = '0;
    logic [BLK_W-1:0] s = b;
    for (int i = 0; i < BLK_W / 8; i++) begin
      r = (r << 8) | BLK_W'(s[7:0]);
      s = s >> 8;
    end
    return r;
  endfunction

  // Reference: collect words as a list, emit on N words or in_last.
  task automatic model_accept(input logic [IN_W-1:0] d, input logic l, input logic s);
    exp_t e;
    logic [BLK_W-1:0] blk;
    if (m_words.size() == 0) m_swap = s;
    m_words.push_back(d);
    if (m_words.size() == N || l) begin
      blk = '0;
      foreach (m_words[i]) blk = (blk << IN_W) | BLK_W'(m_words[i]);
      blk = blk << ((N - m_words.size()) * IN_W);
      e.d = m_swap ? ref_rev(blk) : blk;
      e.l = l;
      exp_q.push_back(e);
      m_words.delete();
    end
  endtask

  task automatic chk(input string name, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic chki(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send_word(input logic [IN_W-1:0] d, input logic l, input logic s);
    bit got = 0;
    int n = 0;
    in_data  = d;
    in_last  = l;
    swap_en  = s;
    in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=no_accept want=accept data=%h", d);
    end else begin
      if (n > 1) stalls++;
      model_accept(d, l, s);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_block got=%h want=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.d || out_last !== e.l) begin
          bad++;
          $display("FAIL block got=%h/%b want=%h/%b", out_data, out_last, e.d, e.l);
        end
      end
      last_out  = out_data;
      last_outl = out_last;
      pop_cyc.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit tp_ok;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    swap_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, '0);

    // Reset mid-block discards the partial word
    send_word(64'h0011_2233_4455_6677, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk1("midblk_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    m_words.delete();
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_word(64'h1111_2222_3333_4444, 1'b0, 1'b0);
    send_word(64'h5555_6666_7777_8888, 1'b0, 1'b0);
    idle(4);
    chk("after_rst_block", last_out, 128'h1111_2222_3333_4444_5555_6666_7777_8888);

    // No swap, with latency check
    send_word(64'h0011_2233_4455_6677, 1'b0, 1'b0);
    send_word(64'h8899_AABB_CCDD_EEFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk1("lat_not_yet", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("lat_valid", out_valid, 1'b1);
    idle(3);
    chk("noswap_data", last_out, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    chk1("noswap_last", last_outl, 1'b0);

    // Swap latched from the first word only
    send_word(64'h0011_2233_4455_6677, 1'b0, 1'b1);
    send_word(64'h8899_AABB_CCDD_EEFF, 1'b0, 1'b0);
    idle(4);
    chk("swap_data", last_out, 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100);

    // Short block with zero padding
    send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0);
    idle(4);
    chk("short_data", last_out, 128'hDEAD_BEEF_CAFE_F00D_0000_0000_0000_0000);
    chk1("short_last", last_outl, 1'b1);

    // Full block closed by in_last on word N
    send_word(64'h0102_0304_0506_0708, 1'b0, 1'b1);
    send_word(64'h090A_0B0C_0D0E_0F10, 1'b1, 1'b0);
    idle(4);
    chk("fulllast_data", last_out, 128'h100F_0E0D_0C0B_0A09_0807_0605_0403_0201);
    chk1("fulllast_last", last_outl, 1'b1);

    // Backpressure: two blocks parked, input stalls, then drains in order
    pop_cyc.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 1'b0, 1'($urandom));
    chk1("bp_in_ready", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk1("bp_in_ready_held", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) send_word({$urandom, $urandom}, 1'b0, 1'($urandom));
    idle(6);
    chki("bp_blocks", pop_cyc.size(), 3);

    // Throughput: back-to-back blocks with out_ready held high
    pop_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, 1'b0, 1'($urandom));
    idle(8);
    chki("tp_stalls", stalls, 0);
    chki("tp_blocks", pop_cyc.size(), 4);
    tp_ok = (pop_cyc.size() == 4);
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] - pop_cyc[i-1] != 2) tp_ok = 0;
    chk1("tp_spacing", tp_ok, 1'b1);

    // Randomized traffic with random backpressure
    bp_en = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_word({$urandom, $urandom}, (i == 299) || ($urandom_range(0, 6) == 0), 1'($urandom));
    end
    in_valid = 1'b0;
    bp_en = 0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    chki("drain_queue", exp_q.size(), 0);
    chk1("drain_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
